// File: rtl/class_vote_buffer.sv
// Purpose : sliding-window majority vote over classifier labels, with drop and finish tracking.
// Latency : vote strobe two edges after the accepting edge; drop strobe one edge after.
// Backpres: none; i_enable=0 freezes all state, one accept per cycle sustained.
//
// Ports:
//   i_clk, i_rst         - clock (rising edge), asynchronous active-high reset
//   i_enable             - accept enable; low pauses the block
//   i_done/i_class_label - label strobe and label from the classifier
//   o_vote_valid         - one-cycle strobe qualifying o_vote_label / o_vote_count
//   o_vote_label/count   - majority label over the window and its occurrence count
//   o_sample_count       - labels accepted so far (saturates at MAX_SAMPLES)
//   o_drop               - one-cycle strobe for a rejected out-of-range label
//   o_finished           - level, high once MAX_SAMPLES labels have been accepted
//
// Optional feature macro: CLASS_VOTE_PARTIAL_EN - also vote on accepts made while filling.
module class_vote_buffer #(
  parameter int LABEL_W     = 4,
  parameter int N_CLASSES   = 10,
  parameter int WINDOW      = 8,
  parameter int MAX_SAMPLES = 9745,
  localparam int CNT_W      = $clog2(WINDOW + 1),
  localparam int SMP_W      = $clog2(MAX_SAMPLES + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic               i_done,
  input  logic [LABEL_W-1:0] i_class_label,
  output logic               o_vote_valid,
  output logic [LABEL_W-1:0] o_vote_label,
  output logic [CNT_W-1:0]   o_vote_count,
  output logic [SMP_W-1:0]   o_sample_count,
  output logic               o_drop,
  output logic               o_finished
);

  localparam int PTR_W = $clog2(WINDOW);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [LABEL_W-1:0] ring [WINDOW];
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   fill_cnt;
  logic [CNT_W-1:0]   hist [N_CLASSES];
  logic               vote_pend;

  logic               label_ok;
  logic               accept;
  logic               drop_nxt;
  logic               fill_last;
  logic               samp_last;
  logic               vote_pend_nxt;
  logic [LABEL_W-1:0] old_lbl;
  logic [N_CLASSES-1:0] hist_inc;
  logic [N_CLASSES-1:0] hist_dec;
  logic [LABEL_W-1:0] best_lbl;
  logic [CNT_W-1:0]   best_cnt;

  // Widen by one bit so N_CLASSES == 2**LABEL_W still compares correctly.
  assign label_ok  = ({1'b0, i_class_label} < (LABEL_W + 1)'(N_CLASSES));
  assign fill_last = (fill_cnt == CNT_W'(WINDOW - 1));
  assign samp_last = (o_sample_count == SMP_W'(MAX_SAMPLES - 1));
  // Label about to be overwritten; only meaningful once the ring is full (RUN).
  assign old_lbl   = ring[wr_ptr];
  assign o_finished = (state == S_DONE);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-cycle decodes
  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    drop_nxt      = 1'b0;
    vote_pend_nxt = 1'b0;

    if ((state == S_FILL || state == S_RUN) && i_enable && i_done) begin
      if (label_ok) begin
        accept = 1'b1;
      end else begin
        drop_nxt = 1'b1;
      end
    end

    case (state)
      S_IDLE: begin
        if (i_enable) begin
          state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        // Finishing takes priority when MAX_SAMPLES is smaller than the window.
        if (accept && samp_last) begin
          state_nxt = S_DONE;
        end else if (accept && fill_last) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (accept && samp_last) begin
          state_nxt = S_DONE;
        end
      end
      default: begin
        state_nxt = S_DONE;
      end
    endcase

`ifdef CLASS_VOTE_PARTIAL_EN
    vote_pend_nxt = accept;
`else
    // The accept that completes the fill already sees a full window.
    vote_pend_nxt = accept && ((state == S_RUN) || fill_last);
`endif
  end

  // Histogram increment/decrement requests per class
  always_comb begin
    hist_inc = '0;
    hist_dec = '0;
    for (int c = 0; c < N_CLASSES; c++) begin
      hist_inc[c] = accept && (i_class_label == LABEL_W'(c));
      hist_dec[c] = accept && (state == S_RUN) && (old_lbl == LABEL_W'(c));
    end
  end

  // Argmax; strict '>' keeps the lowest class index on ties.
  always_comb begin
    best_lbl = '0;
    best_cnt = hist[0];
    for (int c = 1; c < N_CLASSES; c++) begin
      if (hist[c] > best_cnt) begin
        best_lbl = LABEL_W'(c);
        best_cnt = hist[c];
      end
    end
  end

  // Ring storage needs no reset: histogram and fill count gate every read.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      ring[wr_ptr] <= i_class_label;
    end
  end

  // Pointers, counters and histogram
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr         <= '0;
      fill_cnt       <= '0;
      o_sample_count <= '0;
      for (int c = 0; c < N_CLASSES; c++) begin
        hist[c] <= '0;
      end
    end else begin
      if (accept) begin
        wr_ptr <= (wr_ptr == PTR_W'(WINDOW - 1)) ? '0 : wr_ptr + 1'b1;
        if (state == S_FILL) begin
          fill_cnt <= fill_cnt + 1'b1;
        end
        if (o_sample_count != SMP_W'(MAX_SAMPLES)) begin
          o_sample_count <= o_sample_count + 1'b1;
        end
      end
      for (int c = 0; c < N_CLASSES; c++) begin
        if (hist_inc[c] && !hist_dec[c]) begin
          hist[c] <= hist[c] + 1'b1;
        end else if (hist_dec[c] && !hist_inc[c]) begin
          hist[c] <= hist[c] - 1'b1;
        end
      end
    end
  end

  // Vote pipeline: the pending flag lets the histogram settle for one edge
  // before the argmax is captured.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vote_pend    <= 1'b0;
      o_vote_valid <= 1'b0;
      o_vote_label <= '0;
      o_vote_count <= '0;
      o_drop       <= 1'b0;
    end else begin
      vote_pend    <= vote_pend_nxt;
      o_vote_valid <= vote_pend;
      o_drop       <= drop_nxt;
      if (vote_pend) begin
        o_vote_label <= best_lbl;
        o_vote_count <= best_cnt;
      end
    end
  end

endmodule

// File: tb/tb_class_vote_buffer.sv
module tb_class_vote_buffer;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_enable = 1'b0;
  logic       i_done = 1'b0;
  logic [3:0] i_class_label = '0;
  logic       o_vote_valid;
  logic [3:0] o_vote_label;
  logic [3:0] o_vote_count;
  logic [4:0] o_sample_count;
  logic       o_drop;
  logic       o_finished;

  int checks = 0;
  int errors = 0;

  class_vote_buffer #(
    .LABEL_W(4), .N_CLASSES(10), .WINDOW(8), .MAX_SAMPLES(20)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_done(i_done),
    .i_class_label(i_class_label), .o_vote_valid(o_vote_valid),
    .o_vote_label(o_vote_label), .o_vote_count(o_vote_count),
    .o_sample_count(o_sample_count), .o_drop(o_drop), .o_finished(o_finished)
  );

  always #5 i_clk = ~i_clk;

  // One row = inputs held across one rising edge, outputs expected afterwards.
  typedef struct {
    bit en;
    bit dn;
    int lbl;
    bit vld;
    int vlbl;
    int vcnt;
    bit drop;
    int scnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit en, bit dn, int lbl, bit vld, int vlbl,
                              int vcnt, bit drop, int scnt);
    vec_t v;
    v.en = en; v.dn = dn; v.lbl = lbl; v.vld = vld;
    v.vlbl = vlbl; v.vcnt = vcnt; v.drop = drop; v.scnt = scnt;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at the negedge after IDLE->FILL,
  // so the next rising edge is the first one that can accept.
  task automatic apply_reset(input string tag);
    i_rst = 1'b1; i_enable = 1'b0; i_done = 1'b0; i_class_label = '0;
    #1;
    chk({tag, " rst vld"},  int'(o_vote_valid), 0);
    chk({tag, " rst lbl"},  int'(o_vote_label), 0);
    chk({tag, " rst cnt"},  int'(o_vote_count), 0);
    chk({tag, " rst scnt"}, int'(o_sample_count), 0);
    chk({tag, " rst drop"}, int'(o_drop), 0);
    chk({tag, " rst fin"},  int'(o_finished), 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      chk({tag, " rst hold vld"}, int'(o_vote_valid), 0);
    end
    i_rst = 1'b0;
    i_enable = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      i_enable = vecs[i].en;
      i_done = vecs[i].dn;
      i_class_label = 4'(vecs[i].lbl);
      @(posedge i_clk);
      @(negedge i_clk);
      chk($sformatf("%s[%0d] vld", tag, i),  int'(o_vote_valid),   int'(vecs[i].vld));
      chk($sformatf("%s[%0d] lbl", tag, i),  int'(o_vote_label),   vecs[i].vlbl);
      chk($sformatf("%s[%0d] cnt", tag, i),  int'(o_vote_count),   vecs[i].vcnt);
      chk($sformatf("%s[%0d] drop", tag, i), int'(o_drop),         int'(vecs[i].drop));
      chk($sformatf("%s[%0d] scnt", tag, i), int'(o_sample_count), vecs[i].scnt);
      chk($sformatf("%s[%0d] fin", tag, i),  int'(o_finished),     0);
    end
    i_done = 1'b0;
    i_enable = 1'b1;
    vecs.delete();
  endtask

  function automatic void load_fill();
    for (int k = 1; k <= 8; k++) add(1, 1, 3, 0, 0, 0, 0, k);
    add(1, 0, 0, 1, 3, 8, 0, 8);
    add(1, 0, 0, 0, 3, 8, 0, 8);
  endfunction

  int exp_wl[8] = '{1, 1, 1, 1, 1, 6, 6, 6};
  int exp_wc[8] = '{8, 7, 6, 5, 4, 5, 6, 7};

  initial begin
    int strobes;

    // Plain fill of eight identical labels
    @(negedge i_clk);
    apply_reset("fill");
    load_fill();
    run_vecs("fill");

    // Tie: four 5s then four 2s -> lowest index wins
    apply_reset("tie");
    for (int k = 1; k <= 4; k++) add(1, 1, 5, 0, 0, 0, 0, k);
    for (int k = 5; k <= 8; k++) add(1, 1, 2, 0, 0, 0, 0, k);
    add(1, 0, 0, 1, 2, 4, 0, 8);
    add(1, 0, 0, 0, 2, 4, 0, 8);
    run_vecs("tie");

    // Wrap: eight 1s then eight 6s, then drop and enable-low checks
    apply_reset("wrap");
    for (int k = 1; k <= 8; k++) add(1, 1, 1, 0, 0, 0, 0, k);
    for (int k = 9; k <= 16; k++) add(1, 1, 6, 1, exp_wl[k-9], exp_wc[k-9], 0, k);
    add(1, 0, 0, 1, 6, 8, 0, 16);
    add(1, 0, 0, 0, 6, 8, 0, 16);
    add(1, 1, 12, 0, 6, 8, 1, 16);
    add(1, 0, 0, 0, 6, 8, 0, 16);
    add(0, 1, 0, 0, 6, 8, 0, 16);
    add(1, 0, 0, 0, 6, 8, 0, 16);
    run_vecs("wrap");

    // Finish: 25 back-to-back strobes with MAX_SAMPLES=20
    apply_reset("fin");
    strobes = 0;
    for (int i = 1; i <= 25; i++) begin
      i_done = 1'b1;
      i_class_label = 4'd7;
      @(posedge i_clk);
      @(negedge i_clk);
      if (o_vote_valid) strobes++;
      if (i == 19) begin
        chk("fin pre scnt", int'(o_sample_count), 19);
        chk("fin pre fin", int'(o_finished), 0);
      end
      if (i == 20) chk("fin at20 fin", int'(o_finished), 1);
    end
    i_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      if (o_vote_valid) strobes++;
    end
    chk("fin strobes", strobes, 13);
    chk("fin scnt", int'(o_sample_count), 20);
    chk("fin finished", int'(o_finished), 1);
    chk("fin lbl", int'(o_vote_label), 7);
    chk("fin cnt", int'(o_vote_count), 8);

    // Reset one cycle after an accept in RUN, then refill
    apply_reset("mid");
    for (int i = 1; i <= 9; i++) begin
      i_done = 1'b1;
      i_class_label = (i == 9) ? 4'd4 : 4'd3;
      @(posedge i_clk);
      @(negedge i_clk);
    end
    apply_reset("mid2");
    chk("mid post vld", int'(o_vote_valid), 0);
    load_fill();
    run_vecs("refill");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
